hack_run_ctrl: RTL and testbench

- Parametrised run-control and trace block for the Hack computer; successor to the fixed free-running top-level.
- Sits between the CPU and ROM/Memory. Observes pc, instruction, addressM, outM and writeM, and generates the CPU cycle-enable and the gated memory write.
- Adds halt/run/single-step, one PC breakpoint, a saturating executed-cycle counter, and a first-word-fall-through trace FIFO of executed cycles.

---
 rtl/hack_dbg_pkg.sv | 17 +
 rtl/hack_trace_fifo.sv | 47 ++++
 rtl/hack_run_ctrl.sv | 77 +++++++
 tb/tb_hack_run_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hack_dbg_pkg.sv
// hack_dbg_pkg: state encoding and trace entry layout shared by the Hack run-control slice
package hack_dbg_pkg;
  localparam logic [1:0] ST_HALT  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_STEP  = 2'b10;
  localparam logic [1:0] ST_BREAK = 2'b11;
  typedef struct packed {
    logic [14:0] pc;
    logic [15:0] instr;
    logic [15:0] addr;
    logic [15:0] data;
    logic        we;
  } trace_entry_t;
  function automatic int trace_w(input int data_w, input int pc_w);
    return pc_w + 3 * data_w + 1;
  endfunction
endpackage

// File: rtl/hack_trace_fifo.sv
// hack_trace_fifo: first-word-fall-through FIFO with sticky drop flag and synchronous flush
module hack_trace_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop_ok, push_ok;
  assign full    = count == (AW+1)'(DEPTH);
  assign valid   = count != '0;
  assign pop_ok  = pop & valid;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = valid ? mem[rd_ptr] : '0;
  // pointers, occupancy and sticky drop flag; a flush beats any push or pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      if (push & ~push_ok) overflow <= 1'b1;
    end
  // entry storage; left unreset because the head is masked to zero while empty
  always_ff @(posedge clk)
    if (push_ok & ~clr) mem[wr_ptr] <= din;
endmodule

// File: rtl/hack_run_ctrl.sv
// hack_run_ctrl: halt/run/step control, PC breakpoint, cycle counter and trace for the Hack CPU
module hack_run_ctrl
  import hack_dbg_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int PC_W        = 15,
  parameter int CNT_W       = 32,
  parameter int TRACE_DEPTH = 16,
  parameter int TRACE_ALL   = 0,
  parameter int START_RUN   = 1
) (
  input  logic                           CLK,
  input  logic                           reset,
  input  logic                           run,
  input  logic                           halt,
  input  logic                           step,
  input  logic                           bp_en,
  input  logic [PC_W-1:0]                bp_addr,
  input  logic [PC_W-1:0]                pc,
  input  logic [DATA_W-1:0]              instruction,
  input  logic [DATA_W-1:0]              addressM,
  input  logic [DATA_W-1:0]              outM,
  input  logic                           writeM,
  output logic                           cpu_ce,
  output logic                           mem_we,
  output logic [1:0]                     state,
  output logic [CNT_W-1:0]               cycle_count,
  input  logic                           trace_rd,
  input  logic                           trace_clr,
  output logic                           trace_valid,
  output logic [PC_W-1:0]                trace_pc,
  output logic [DATA_W-1:0]              trace_instr,
  output logic [DATA_W-1:0]              trace_addr,
  output logic [DATA_W-1:0]              trace_data,
  output logic                           trace_we,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count,
  output logic                           trace_overflow
);
  localparam int TW = trace_w(DATA_W, PC_W);
  logic          first, bp_hit, push;
  logic [1:0]    state_nx;
  logic [TW-1:0] head;
  assign bp_hit = state == ST_RUN && bp_en && pc == bp_addr && !first;
  assign cpu_ce = state == ST_STEP || (state == ST_RUN && !bp_hit);
  assign mem_we = writeM & cpu_ce;
  assign push   = cpu_ce & ((TRACE_ALL != 0) | writeM);
  // next state; halt outranks run, run outranks step
  always_comb
    state_nx = state == ST_RUN  ? (halt ? ST_HALT : bp_hit ? ST_BREAK : ST_RUN)
             : state == ST_STEP ? (run && !halt ? ST_RUN : ST_HALT)
             : halt ? state : run ? ST_RUN : step ? ST_STEP : state;
  // state, breakpoint-skip flag (lets a resume execute the breakpoint word) and saturating counter
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      state       <= START_RUN != 0 ? ST_RUN : ST_HALT;
      first       <= 1'b1;
      cycle_count <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state && (state_nx == ST_RUN || state_nx == ST_STEP)) first <= 1'b1;
      else if (cpu_ce) first <= 1'b0;
      if (cpu_ce && cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
    end
  hack_trace_fifo #(.W(TW), .DEPTH(TRACE_DEPTH)) u_fifo (
    .clk      (CLK),
    .rst_n    (reset),
    .push     (push),
    .pop      (trace_rd),
    .clr      (trace_clr),
    .din      ({pc, instruction, addressM, outM, writeM}),
    .dout     (head),
    .valid    (trace_valid),
    .count    (trace_count),
    .overflow (trace_overflow)
  );
  assign {trace_pc, trace_instr, trace_addr, trace_data, trace_we} = head;
endmodule

// File: tb/tb_hack_run_ctrl.sv
// tb_hack_run_ctrl: directed vector table plus hand sequences for hack_run_ctrl
module tb_hack_run_ctrl;
  logic clk = 1'b0;
  logic reset, run, halt, step, bp_en, writeM, trace_rd, trace_clr;
  logic [14:0] bp_addr, pc;
  logic [15:0] instruction, addressM, outM;
  logic a_ce, a_we, a_tv, a_twe, a_ovf;
  logic [1:0] a_st;
  logic [3:0] a_cnt;
  logic [14:0] a_tpc;
  logic [15:0] a_ti, a_ta, a_td;
  logic [2:0] a_tcnt;
  logic b_ce, b_we, b_tv, b_twe, b_ovf;
  logic [1:0] b_st;
  logic [31:0] b_cnt;
  logic [14:0] b_tpc;
  logic [15:0] b_ti, b_ta, b_td;
  logic [4:0] b_tcnt;
  int total = 0;
  int passed = 0;
  always #10 clk = ~clk;
  hack_run_ctrl #(.CNT_W(4), .TRACE_DEPTH(4), .TRACE_ALL(0), .START_RUN(1)) u_a (
    .CLK(clk), .reset(reset), .run(run), .halt(halt), .step(step), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc), .instruction(instruction), .addressM(addressM),
    .outM(outM), .writeM(writeM), .cpu_ce(a_ce), .mem_we(a_we), .state(a_st),
    .cycle_count(a_cnt), .trace_rd(trace_rd), .trace_clr(trace_clr),
    .trace_valid(a_tv), .trace_pc(a_tpc), .trace_instr(a_ti), .trace_addr(a_ta),
    .trace_data(a_td), .trace_we(a_twe), .trace_count(a_tcnt), .trace_overflow(a_ovf)
  );
  hack_run_ctrl #(.CNT_W(32), .TRACE_DEPTH(16), .TRACE_ALL(1), .START_RUN(0)) u_b (
    .CLK(clk), .reset(reset), .run(run), .halt(halt), .step(step), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc), .instruction(instruction), .addressM(addressM),
    .outM(outM), .writeM(writeM), .cpu_ce(b_ce), .mem_we(b_we), .state(b_st),
    .cycle_count(b_cnt), .trace_rd(trace_rd), .trace_clr(trace_clr),
    .trace_valid(b_tv), .trace_pc(b_tpc), .trace_instr(b_ti), .trace_addr(b_ta),
    .trace_data(b_td), .trace_we(b_twe), .trace_count(b_tcnt), .trace_overflow(b_ovf)
  );
  typedef struct {
    logic run, halt, step, bp_en;
    logic [14:0] bp_addr, pc;
    logic wr, rd, clr, e_ce;
    logic [1:0] e_st;
    logic [3:0] e_cnt;
    logic [2:0] e_tcnt;
    logic e_ovf;
    logic [14:0] e_hpc;
  } vec_t;
  vec_t vq[$];
  function automatic vec_t v(input logic r, h, s, be, input int ba, p, input logic w, rd, cl, ce,
                             input int st, cnt, tc, input logic ov, input int hp);
    vec_t x;
    x.run = r; x.halt = h; x.step = s; x.bp_en = be;
    x.bp_addr = 15'(ba); x.pc = 15'(p); x.wr = w; x.rd = rd; x.clr = cl; x.e_ce = ce;
    x.e_st = 2'(st); x.e_cnt = 4'(cnt); x.e_tcnt = 3'(tc); x.e_ovf = ov; x.e_hpc = 15'(hp);
    return x;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic set_pc(input logic [14:0] p);
    pc = p;
    instruction = 16'h7000 + {1'b0, p};
    addressM = 16'h0100 + {1'b0, p};
    outM = 16'hBEE0 + {1'b0, p};
  endtask
  task automatic idle();
    run = 0; halt = 0; step = 0; bp_en = 0; bp_addr = '0; writeM = 0; trace_rd = 0; trace_clr = 0;
    set_pc('0);
  endtask
  initial begin
    reset = 1'b0;
    idle();
    //        r h s be ba pc w rd cl ce st cnt tc ov hpc
    vq.push_back(v(0,0,0,0,0, 0,0,0,0,1,1, 1,0,0, 0));
    vq.push_back(v(0,0,0,0,0, 1,0,0,0,1,1, 2,0,0, 0));
    vq.push_back(v(0,0,0,0,0, 2,0,0,0,1,1, 3,0,0, 0));
    vq.push_back(v(0,0,0,0,0, 3,0,0,0,1,1, 4,0,0, 0));
    vq.push_back(v(0,0,0,0,0, 4,0,0,0,1,1, 5,0,0, 0));
    vq.push_back(v(0,0,0,1,3, 0,0,0,0,1,1, 6,0,0, 0));
    vq.push_back(v(0,0,0,1,3, 1,0,0,0,1,1, 7,0,0, 0));
    vq.push_back(v(0,0,0,1,3, 2,0,0,0,1,1, 8,0,0, 0));
    vq.push_back(v(0,0,0,1,3, 3,0,0,0,0,3, 8,0,0, 0));
    vq.push_back(v(0,0,0,1,3, 3,0,0,0,0,3, 8,0,0, 0));
    vq.push_back(v(1,0,0,1,3, 3,0,0,0,0,1, 8,0,0, 0));
    vq.push_back(v(0,0,0,1,3, 3,0,0,0,1,1, 9,0,0, 0));
    vq.push_back(v(0,0,0,1,3, 4,0,0,0,1,1,10,0,0, 0));
    vq.push_back(v(0,0,0,0,0,10,1,0,0,1,1,11,1,0,10));
    vq.push_back(v(0,0,0,0,0,11,1,0,0,1,1,12,2,0,10));
    vq.push_back(v(0,0,0,0,0,12,1,0,0,1,1,13,3,0,10));
    vq.push_back(v(0,0,0,0,0,13,1,0,0,1,1,14,4,0,10));
    vq.push_back(v(0,0,0,0,0,14,1,0,0,1,1,15,4,1,10));
    vq.push_back(v(0,0,0,0,0,15,1,0,0,1,1,15,4,1,10));
    vq.push_back(v(0,0,0,0,0,16,0,0,1,1,1,15,0,0, 0));
    vq.push_back(v(0,0,0,0,0,20,1,0,0,1,1,15,1,0,20));
    vq.push_back(v(0,0,0,0,0,21,1,0,0,1,1,15,2,0,20));
    vq.push_back(v(0,0,0,0,0,22,1,0,0,1,1,15,3,0,20));
    vq.push_back(v(0,0,0,0,0,23,1,0,0,1,1,15,4,0,20));
    vq.push_back(v(0,0,0,0,0,24,1,1,0,1,1,15,4,0,21));
    vq.push_back(v(0,1,0,0,0,25,0,0,0,1,0,15,4,0,21));
    vq.push_back(v(0,0,1,0,0,26,0,0,0,0,2,15,4,0,21));
    vq.push_back(v(0,1,0,0,0,26,0,0,0,1,0,15,4,0,21));
    vq.push_back(v(1,0,0,0,0,27,0,0,0,0,1,15,4,0,21));
    vq.push_back(v(0,0,0,0,0,27,0,0,0,1,1,15,4,0,21));
    repeat (2) @(posedge clk);
    #1;
    chk("rst a state", 32'(a_st), 32'h1);
    chk("rst a ce", 32'(a_ce), 32'h1);
    chk("rst a cnt", 32'(a_cnt), 32'h0);
    chk("rst a valid", 32'(a_tv), 32'h0);
    chk("rst a tpc", 32'(a_tpc), 32'h0);
    chk("rst b state", 32'(b_st), 32'h0);
    chk("rst b ce", 32'(b_ce), 32'h0);
    #1 reset = 1'b1;
    foreach (vq[i]) begin
      @(negedge clk);
      run = vq[i].run; halt = vq[i].halt; step = vq[i].step; bp_en = vq[i].bp_en;
      bp_addr = vq[i].bp_addr; writeM = vq[i].wr; trace_rd = vq[i].rd; trace_clr = vq[i].clr;
      set_pc(vq[i].pc);
      #1;
      chk($sformatf("v%0d ce", i), 32'(a_ce), 32'(vq[i].e_ce));
      chk($sformatf("v%0d mem_we", i), 32'(a_we), 32'(vq[i].wr & vq[i].e_ce));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d state", i), 32'(a_st), 32'(vq[i].e_st));
      chk($sformatf("v%0d cnt", i), 32'(a_cnt), 32'(vq[i].e_cnt));
      chk($sformatf("v%0d tcount", i), 32'(a_tcnt), 32'(vq[i].e_tcnt));
      chk($sformatf("v%0d ovf", i), 32'(a_ovf), 32'(vq[i].e_ovf));
      chk($sformatf("v%0d head pc", i), 32'(a_tpc), 32'(vq[i].e_hpc));
      chk($sformatf("v%0d valid", i), 32'(a_tv), 32'(vq[i].e_tcnt != 0));
    end
    chk("a head instr", 32'(a_ti), 32'h7015);
    chk("a head addr", 32'(a_ta), 32'h0115);
    chk("a head data", 32'(a_td), 32'hBEF5);
    chk("a head we", 32'(a_twe), 32'h1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_pc(15'(28 + k));
      @(posedge clk);
      #1;
      chk("sat cnt", 32'(a_cnt), 32'hF);
      chk("sat state", 32'(a_st), 32'h1);
    end
    @(negedge clk);
    idle();
    #3 reset = 1'b0;
    #2;
    chk("mid rst a cnt", 32'(a_cnt), 32'h0);
    chk("mid rst a state", 32'(a_st), 32'h1);
    chk("mid rst a tcount", 32'(a_tcnt), 32'h0);
    chk("mid rst a valid", 32'(a_tv), 32'h0);
    chk("mid rst a tpc", 32'(a_tpc), 32'h0);
    chk("mid rst b state", 32'(b_st), 32'h0);
    chk("mid rst b cnt", 32'(b_cnt), 32'h0);
    #2 reset = 1'b1;
    @(negedge clk);
    step = 1; set_pc(15'd5);
    #1 chk("b step0 ce", 32'(b_ce), 32'h0);
    @(posedge clk);
    #1 chk("b step0 state", 32'(b_st), 32'h2);
    @(negedge clk);
    step = 0; set_pc(15'd6);
    #1 chk("b step1 ce", 32'(b_ce), 32'h1);
    @(posedge clk);
    #1;
    chk("b step1 state", 32'(b_st), 32'h0);
    chk("b step1 cnt", 32'(b_cnt), 32'h1);
    chk("b step1 tcount", 32'(b_tcnt), 32'h1);
    chk("b step1 tpc", 32'(b_tpc), 32'h6);
    @(negedge clk);
    step = 1; set_pc(15'd7);
    #1 chk("b step2 ce", 32'(b_ce), 32'h0);
    @(posedge clk);
    #1 chk("b step2 state", 32'(b_st), 32'h2);
    @(negedge clk);
    step = 0; set_pc(15'd9);
    @(posedge clk);
    #1;
    chk("b step3 state", 32'(b_st), 32'h0);
    chk("b step3 cnt", 32'(b_cnt), 32'h2);
    chk("b step3 tcount", 32'(b_tcnt), 32'h2);
    chk("b step3 tpc", 32'(b_tpc), 32'h6);
    chk("b step3 tinstr", 32'(b_ti), 32'h7006);
    @(negedge clk);
    trace_rd = 1;
    @(posedge clk);
    #1;
    chk("b pop tcount", 32'(b_tcnt), 32'h1);
    chk("b pop tpc", 32'(b_tpc), 32'h9);
    chk("b pop tinstr", 32'(b_ti), 32'h7009);
    chk("b pop tdata", 32'(b_td), 32'hBEE9);
    chk("b pop twe", 32'(b_twe), 32'h0);
    chk("b pop state", 32'(b_st), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
